// File: rtl/shift_left_seq.sv
// Iterative left shifter: moves rs1 left by imm, at most STEP bits per cycle, over valid/ready handshakes.
// Optional SHL_ROTATE_EN adds a rot input that turns each step into a rotate-left.
module shift_left_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN),
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1,
  input  logic [SHW-1:0]  imm,
`ifdef SHL_ROTATE_EN
  input  logic            rot,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_left,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHW-1:0] STEP_W = SHW'(STEP);

  state_t          state, state_n;
  logic [XLEN-1:0] acc;
  logic [SHW-1:0]  cnt;
  logic [SHW-1:0]  s;
  logic [SHW-1:0]  cnt_rem;
  logic [XLEN-1:0] acc_step;

  // Never shift by more than what is left, so the final step may be short.
  assign s       = (cnt < STEP_W) ? cnt : STEP_W;
  assign cnt_rem = cnt - s;

`ifdef SHL_ROTATE_EN
  logic            rot_q;
  logic [SHW:0]    rs_amt;
  assign rs_amt   = (SHW+1)'(XLEN) - {1'b0, s};
  assign acc_step = rot_q ? ((acc << s) | (acc >> rs_amt)) : (acc << s);
`else
  assign acc_step = acc << s;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = (imm == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt_rem == '0) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    rd_left   = acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
`ifdef SHL_ROTATE_EN
      rot_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc <= rs1;
          cnt <= imm;
`ifdef SHL_ROTATE_EN
          rot_q <= rot;
`endif
        end
        SHIFT: begin
          acc <= acc_step;
          cnt <= cnt_rem;
        end
        default: ;
      endcase
    end
  end

endmodule
